// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer for the shared L2 bus: ADDR -> SNOOP -> (WRITEBACK) -> DONE.
// Latency: request sampled in IDLE at t gives grant/bus_valid at t+1 and done at t+2+SNOOP_LAT without writeback.
// Backpressure: none on the request side (req held until done); WRITEBACK stalls until wb_done_i (or watchdog expiry).
//
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   req_i                 per-agent request, held until that agent's done
//   req_cmd_i/req_addr_i  per-agent command (00 R, 01 W, 10 M, 11 I) and address
//   grant_o, done_o       one-hot owner (ADDR..DONE), one-hot 1-cycle completion
//   bus_valid_o           command/address strobe, with bus_cmd_o/bus_addr_o
//   snoop_in_i            per-agent snoop reply (00 MISS, 01 HIT, 10 HITM, 11 treated as HITM)
//   snoop_result_o        merged snoop result, valid with done
//   wb_done_i, timeout_o  owner writeback complete; watchdog expiry pulse
// Optional feature: define SHARED_BUS_TIMEOUT_EN to enable the writeback watchdog.
module shared_bus_arbiter #(
   parameter int NUM_AGENTS     = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int SNOOP_LAT      = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NUM_AGENTS-1:0]            req_i,
   input  logic [2*NUM_AGENTS-1:0]          req_cmd_i,
   input  logic [ADDR_WIDTH*NUM_AGENTS-1:0] req_addr_i,
   output logic [NUM_AGENTS-1:0]            grant_o,
   output logic [NUM_AGENTS-1:0]            done_o,
   output logic                             bus_valid_o,
   output logic [1:0]                       bus_cmd_o,
   output logic [ADDR_WIDTH-1:0]            bus_addr_o,
   input  logic [2*NUM_AGENTS-1:0]          snoop_in_i,
   output logic [1:0]                       snoop_result_o,
   input  logic                             wb_done_i,
   output logic                             timeout_o
);

   localparam int IDX_W = $clog2(NUM_AGENTS);
   localparam int CNT_W = $clog2(SNOOP_LAT + 1);

   localparam logic [1:0] CMD_I   = 2'b11;
   localparam logic [1:0] SN_MISS = 2'b00;
   localparam logic [1:0] SN_HIT  = 2'b01;
   localparam logic [1:0] SN_HITM = 2'b10;

   if (NUM_AGENTS < 2 || NUM_AGENTS > 8 || SNOOP_LAT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("shared_bus_arbiter: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_SNOOP, S_WRITEBACK, S_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        rr_q, rr_d;
   logic [IDX_W-1:0]        win_q, win_d;
   logic [NUM_AGENTS-1:0]   grant_q, grant_d;
   logic [NUM_AGENTS-1:0]   done_q, done_d;
   logic                    valid_q, valid_d;
   logic [1:0]              cmd_q, cmd_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [1:0]              merged_q, merged_d;
   logic [1:0]              result_q, result_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   // Arbitration results
   logic                    arb_found;
   logic [IDX_W-1:0]        arb_idx;
   logic [IDX_W-1:0]        cand;
   logic [NUM_AGENTS-1:0]   arb_onehot;
   logic [1:0]              arb_cmd;
   logic [ADDR_WIDTH-1:0]   arb_addr;

   // Snoop merge
   logic                    any_hit, any_hitm;
   logic [1:0]              merge_now;

`ifdef SHARED_BUS_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0]         wd_q, wd_d;
   logic                    timeout_q, timeout_d;
`endif

   // First requester at or after rr_q, wrapping around the agent ring.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_AGENTS; i++) begin
         cand = IDX_W'((int'(rr_q) + i) % NUM_AGENTS);
         if (!arb_found && req_i[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   // Constant-index mux of the winner's command/address.
   always_comb begin
      arb_onehot = '0;
      arb_cmd    = '0;
      arb_addr   = '0;
      for (int i = 0; i < NUM_AGENTS; i++) begin
         if (IDX_W'(i) == arb_idx) begin
            arb_onehot[i] = 1'b1;
            arb_cmd       = req_cmd_i[2*i +: 2];
            arb_addr      = req_addr_i[ADDR_WIDTH*i +: ADDR_WIDTH];
         end
      end
   end

   // The owner's own reply is ignored; an illegal 11 is pessimistically a HITM.
   always_comb begin
      any_hit  = 1'b0;
      any_hitm = 1'b0;
      for (int i = 0; i < NUM_AGENTS; i++) begin
         if (IDX_W'(i) != win_q) begin
            case (snoop_in_i[2*i +: 2])
               2'b10, 2'b11: any_hitm = 1'b1;
               2'b01:        any_hit  = 1'b1;
               default:      ;
            endcase
         end
      end
      merge_now = any_hitm ? SN_HITM : (any_hit ? SN_HIT : SN_MISS);
   end

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      win_d    = win_q;
      grant_d  = grant_q;
      done_d   = '0;
      valid_d  = 1'b0;
      cmd_d    = cmd_q;
      addr_d   = addr_q;
      merged_d = merged_q;
      result_d = SN_MISS;
      cnt_d    = cnt_q;
`ifdef SHARED_BUS_TIMEOUT_EN
      wd_d      = wd_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               win_d   = arb_idx;
               grant_d = arb_onehot;
               valid_d = 1'b1;
               cmd_d   = arb_cmd;
               addr_d  = arb_addr;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            cnt_d   = CNT_W'(SNOOP_LAT - 1);
            state_d = S_SNOOP;
         end
         S_SNOOP: begin
            if (cnt_q == '0) begin
               merged_d = merge_now;
               if (merge_now == SN_HITM && cmd_q != CMD_I) begin
                  state_d = S_WRITEBACK;
`ifdef SHARED_BUS_TIMEOUT_EN
                  wd_d    = '0;
`endif
               end else begin
                  state_d  = S_DONE;
                  done_d   = grant_q;
                  result_d = merge_now;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_WRITEBACK: begin
            if (wb_done_i) begin
               state_d  = S_DONE;
               done_d   = grant_q;
               result_d = merged_q;
            end
`ifdef SHARED_BUS_TIMEOUT_EN
            else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
               state_d   = S_DONE;
               done_d    = grant_q;
               result_d  = SN_HITM;
               timeout_d = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
`endif
         end
         S_DONE: begin
            rr_d     = (win_q == IDX_W'(NUM_AGENTS - 1)) ? '0 : win_q + 1'b1;
            grant_d  = '0;
            cmd_d    = '0;
            addr_d   = '0;
            merged_d = SN_MISS;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         rr_q     <= '0;
         win_q    <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         valid_q  <= 1'b0;
         cmd_q    <= '0;
         addr_q   <= '0;
         merged_q <= '0;
         result_q <= '0;
         cnt_q    <= '0;
`ifdef SHARED_BUS_TIMEOUT_EN
         wd_q      <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         win_q    <= win_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         valid_q  <= valid_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         merged_q <= merged_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
`ifdef SHARED_BUS_TIMEOUT_EN
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign grant_o        = grant_q;
   assign done_o         = done_q;
   assign bus_valid_o    = valid_q;
   assign bus_cmd_o      = cmd_q;
   assign bus_addr_o     = addr_q;
   assign snoop_result_o = result_q;
`ifdef SHARED_BUS_TIMEOUT_EN
   assign timeout_o      = timeout_q;
`else
   assign timeout_o      = 1'b0;
`endif

endmodule
